// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between the fetch and data ports with fixed-latency responses.
// Define ARB_PERF_CNT_EN to build the grant/conflict performance counters; otherwise the perf ports are tied to 0.
module mem_port_arbiter #(
  parameter int BITWIDTH     = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,

  input  logic                if_req_i,
  input  logic [BITWIDTH-1:0] if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [BITWIDTH-1:0] if_rdata_o,

  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [BITWIDTH-1:0] dm_addr_i,
  input  logic [BITWIDTH-1:0] dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [BITWIDTH-1:0] dm_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [BITWIDTH-1:0] mem_addr_o,
  output logic [BITWIDTH-1:0] mem_wdata_o,
  input  logic [BITWIDTH-1:0] mem_rdata_i,

  output logic                stall_f_o,
  output logic [31:0]         perf_if_cnt_o,
  output logic [31:0]         perf_dm_cnt_o,
  output logic [31:0]         perf_conflict_cnt_o
);

  // state   | meaning
  // IDLE    | no access in flight, arbitrate every cycle
  // BUSY    | access in flight; lat_cnt counts down to the response cycle (lat_cnt == 1)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [0:0] state_q, state_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic       owner_q, owner_d;
  logic       wr_q, wr_d;
  logic [3:0] starve_q, starve_d;

  logic resp_cycle;
  logic arb;
  logic fetch_wins;
  logic if_win;
  logic dm_win;

  assign resp_cycle = (state_q == ST_BUSY) && (lat_cnt_q == 3'd1);
  assign arb        = (state_q == ST_IDLE) || resp_cycle;

  // Data has priority unless fetch has lost STARVE_LIMIT arbitrations in a row.
  assign fetch_wins = if_req_i && (!dm_req_i || (starve_q == STARVE_MAX));
  assign if_win     = rst_ni && en_i && arb && fetch_wins;
  assign dm_win     = rst_ni && en_i && arb && dm_req_i && !fetch_wins;

  assign if_gnt_o    = if_win;
  assign dm_gnt_o    = dm_win;
  assign mem_req_o   = if_win || dm_win;
  assign mem_we_o    = dm_win && dm_we_i;
  assign mem_addr_o  = if_win ? if_addr_i : (dm_win ? dm_addr_i : '0);
  assign mem_wdata_o = dm_win ? dm_wdata_i : '0;

  assign if_rvalid_o = resp_cycle && (owner_q == OWN_IF);
  assign dm_rvalid_o = resp_cycle && (owner_q == OWN_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = (dm_rvalid_o && !wr_q) ? mem_rdata_i : '0;

  assign stall_f_o = if_req_i && !if_rvalid_o;

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    starve_d  = starve_q;

    if (state_q == ST_BUSY) begin
      if (lat_cnt_q == 3'd1) begin
        state_d   = ST_IDLE;
        lat_cnt_d = 3'd0;
      end else begin
        lat_cnt_d = lat_cnt_q - 3'd1;
      end
    end

    // A grant in the response cycle overrides the return to IDLE.
    if (if_win || dm_win) begin
      state_d   = ST_BUSY;
      lat_cnt_d = LAT_INIT;
      owner_d   = dm_win ? OWN_DM : OWN_IF;
      wr_d      = dm_win && dm_we_i;
    end

    if (if_win) begin
      starve_d = 4'd0;
    end else if (if_req_i && dm_win && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= 3'd0;
      owner_q   <= OWN_IF;
      wr_q      <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      starve_q  <= starve_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_dm_q, perf_dm_d;
  logic [31:0] perf_cf_q, perf_cf_d;
  logic        conflict;

  assign conflict  = if_req_i && dm_req_i && arb && en_i;
  assign perf_if_d = if_win   ? perf_if_q + 32'd1 : perf_if_q;
  assign perf_dm_d = dm_win   ? perf_dm_q + 32'd1 : perf_dm_q;
  assign perf_cf_d = conflict ? perf_cf_q + 32'd1 : perf_cf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_if_q <= 32'd0;
      perf_dm_q <= 32'd0;
      perf_cf_q <= 32'd0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_dm_q <= perf_dm_d;
      perf_cf_q <= perf_cf_d;
    end
  end

  assign perf_if_cnt_o       = perf_if_q;
  assign perf_dm_cnt_o       = perf_dm_q;
  assign perf_conflict_cnt_o = perf_cf_q;
`else
  assign perf_if_cnt_o       = 32'd0;
  assign perf_dm_cnt_o       = 32'd0;
  assign perf_conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, random vs reference model.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int L  = 2;
  localparam int SL = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         en_i = 1'b0;
  logic         if_req_i = 1'b0;
  logic [W-1:0] if_addr_i = '0;
  logic         dm_req_i = 1'b0;
  logic         dm_we_i = 1'b0;
  logic [W-1:0] dm_addr_i = '0;
  logic [W-1:0] dm_wdata_i = '0;
  logic [W-1:0] mem_rdata_i = '0;

  logic         if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
  logic         mem_req_o, mem_we_o, stall_f_o;
  logic [W-1:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0]  perf_if_cnt_o, perf_dm_cnt_o, perf_conflict_cnt_o;

  mem_port_arbiter #(.BITWIDTH(W), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_f_o(stall_f_o), .perf_if_cnt_o(perf_if_cnt_o), .perf_dm_cnt_o(perf_dm_cnt_o),
    .perf_conflict_cnt_o(perf_conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        en;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
    logic [6:0]  flags; // if_gnt dm_gnt if_rvalid dm_rvalid mem_req mem_we stall_f
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } vec_t;

  vec_t tbl[11];

  // reference model state
  int          cyc;
  logic        m_busy;
  int          m_due;
  logic        m_owner;  // 0 = fetch, 1 = data
  logic        m_write;
  int          m_starve;
  logic [31:0] m_pi, m_pd, m_pc;
  logic        if_pend, if_out, dm_pend, dm_out;
  logic [31:0] r_if_addr, r_dm_addr, r_dm_wdata;
  logic        r_dm_we;
  logic        resp, arb, win_if, win_dm;
  logic [6:0]  e_flags;
  logic [31:0] e_if_rdata, e_dm_rdata, e_addr, e_wdata;
  logic [159:0] snap;
  int          k;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {25'b0, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o, mem_we_o, stall_f_o,
            if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o};
  endfunction

  function automatic logic [159:0] perf();
    return {64'b0, perf_if_cnt_o, perf_dm_cnt_o, perf_conflict_cnt_o};
  endfunction

  function automatic logic [159:0] mk(input logic [6:0] f, input logic [31:0] ird, input logic [31:0] drd,
                                      input logic [31:0] ad, input logic [31:0] wd);
    return {25'b0, f, ird, drd, ad, wd};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic en, input logic ifr, input logic [31:0] ifa, input logic dmr,
                       input logic dmw, input logic [31:0] dma, input logic [31:0] dmwd,
                       input logic [31:0] mrd);
    en_i = en; if_req_i = ifr; if_addr_i = ifa; dm_req_i = dmr; dm_we_i = dmw;
    dm_addr_i = dma; dm_wdata_i = dmwd; mem_rdata_i = mrd;
  endtask

  task automatic model_reset();
    cyc = 0; m_busy = 1'b0; m_due = 0; m_owner = 1'b0; m_write = 1'b0; m_starve = 0;
    m_pi = '0; m_pd = '0; m_pc = '0;
    if_pend = 1'b0; if_out = 1'b0; dm_pend = 1'b0; dm_out = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        32'hBAD0_0000, 7'b1000101, 32'h0,        32'h0,        32'h10,  32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        32'hBAD0_0001, 7'b0000001, 32'h0,        32'h0,        32'h0,   32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h0050_0093, 7'b0010000, 32'h0050_0093, 32'h0,       32'h0,   32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'h20,  1'b1, 1'b0, 32'h100, 32'h0,        32'hBAD0_0003, 7'b0100101, 32'h0,        32'h0,        32'h100, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'h20,  1'b0, 1'b0, 32'h104, 32'h0,        32'hBAD0_0004, 7'b0000001, 32'h0,        32'h0,        32'h0,   32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h20,  1'b0, 1'b0, 32'h0,   32'h0,        32'h1111_1111, 7'b1001101, 32'h0,        32'h1111_1111, 32'h20, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h24,  1'b0, 1'b0, 32'h0,   32'h0,        32'hBAD0_0006, 7'b0000000, 32'h0,        32'h0,        32'h0,   32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h2222_2222, 7'b0010000, 32'h2222_2222, 32'h0,       32'h0,   32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'hBAD0_0008, 7'b0100110, 32'h0,        32'h0,        32'h200, 32'hDEAD_BEEF};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'hBAD0_0009, 7'b0000000, 32'h0,        32'h0,        32'h0,   32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h3333_3333, 7'b0001000, 32'h0,        32'h0,        32'h0,   32'h0};

    #3;
    chk("reset_outputs", outs(), 160'b0);
    chk("reset_perf", perf(), 160'b0);
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();

    // directed vectors: single fetch, simultaneous requests, data write
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].if_req, tbl[i].if_addr, tbl[i].dm_req, tbl[i].dm_we,
            tbl[i].dm_addr, tbl[i].dm_wdata, tbl[i].mem_rdata);
      #4;
      chk($sformatf("vec%0d", i), outs(),
          mk(tbl[i].flags, tbl[i].if_rdata, tbl[i].dm_rdata, tbl[i].mem_addr, tbl[i].mem_wdata));
      next_cycle();
    end

    // starvation guard: both requesters held high; every 5th arbitration goes to fetch
    k = 0;
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0);
    for (int c = 0; c < 20; c++) begin
      mem_rdata_i = $urandom;
      #4;
      if (if_gnt_o || dm_gnt_o) begin
        chk($sformatf("starve_arb%0d", k), {158'b0, if_gnt_o, dm_gnt_o},
            ((k % 5) == 4) ? 160'b10 : 160'b01);
        k++;
      end
      next_cycle();
    end
    chk("starve_arb_count", 160'(k), 160'd10);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();

    // reset mid-access discards the response
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_FFFF);
    #4;
    chk("rst_pre_gnt", outs(), mk(7'b1000101, 32'h0, 32'h0, 32'h80, 32'h0));
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 32'hCAFE_0000);
    #1;
    rst_ni = 1'b0;
    #3;
    chk("rst_mid_outputs", outs(), 160'b0);
    chk("rst_mid_perf", perf(), 160'b0);
    next_cycle();
    mem_rdata_i = 32'hCAFE_0001;
    #4;
    chk("rst_hold_outputs", outs(), 160'b0);
    next_cycle();
    rst_ni = 1'b1;
    drive(1'b1, 1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0002);
    #4;
    chk("rst_regrant", outs(), mk(7'b1000101, 32'h0, 32'h0, 32'h84, 32'h0));
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0003);
    #4;
    chk("rst_no_stale_rvalid", outs(), 160'b0);
    next_cycle();
    mem_rdata_i = 32'h0000_1234;
    #4;
    chk("rst_new_rvalid", outs(), mk(7'b0010000, 32'h1234, 32'h0, 32'h0, 32'h0));
    next_cycle();

    // en low: in-flight response still delivered, no new grants, counters frozen
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hBAD0_0010);
    #4;
    chk("en_dm_gnt", outs(), mk(7'b0100100, 32'h0, 32'h0, 32'h400, 32'h0));
    next_cycle();
    drive(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 32'hBAD0_0011);
    #4;
    chk("en0_no_gnt", outs(), mk(7'b0000001, 32'h0, 32'h0, 32'h0, 32'h0));
    snap = perf();
    next_cycle();
    mem_rdata_i = 32'h7777_0000;
    #4;
    chk("en0_dm_rvalid", outs(), mk(7'b0001001, 32'h0, 32'h7777_0000, 32'h0, 32'h0));
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      mem_rdata_i = $urandom;
      #4;
      chk("en0_hold", outs(), mk(7'b0000001, 32'h0, 32'h0, 32'h0, 32'h0));
      next_cycle();
    end
`ifdef ARB_PERF_CNT_EN
    chk("en0_perf_frozen", perf(), snap);
    chk("perf_counted", 160'(perf_if_cnt_o != 32'd0 && perf_dm_cnt_o != 32'd0), 160'd1);
`else
    chk("perf_tied_zero", perf(), 160'b0);
`endif
    en_i = 1'b1;
    #4;
    chk("en1_if_gnt", outs(), mk(7'b1000101, 32'h0, 32'h0, 32'h44, 32'h0));
    next_cycle();
    if_req_i = 1'b0;
    next_cycle();
    next_cycle();

    // randomized traffic against the reference model
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      resp = m_busy && (cyc == m_due);
      if (resp && !m_owner) if_out = 1'b0;
      if (resp && m_owner)  dm_out = 1'b0;
      if (!if_pend && !if_out && ($urandom_range(0, 2) != 0)) begin
        if_pend = 1'b1;
        r_if_addr = $urandom;
      end
      if (!dm_pend && !dm_out && ($urandom_range(0, 2) != 0)) begin
        dm_pend = 1'b1;
        r_dm_we = 1'($urandom_range(0, 1));
        r_dm_addr = $urandom;
        r_dm_wdata = $urandom;
      end
      en_i       = ($urandom_range(0, 7) != 0);
      if_req_i   = if_pend;
      if_addr_i  = if_pend ? r_if_addr : $urandom;
      dm_req_i   = dm_pend;
      dm_we_i    = dm_pend ? r_dm_we : 1'($urandom_range(0, 1));
      dm_addr_i  = dm_pend ? r_dm_addr : $urandom;
      dm_wdata_i = dm_pend ? r_dm_wdata : $urandom;
      mem_rdata_i = $urandom;
      #4;

      arb = !m_busy || resp;
      win_if = 1'b0;
      win_dm = 1'b0;
      if (arb && en_i) begin
        if (if_pend && dm_pend) begin
          if (m_starve == SL) win_if = 1'b1;
          else win_dm = 1'b1;
        end else if (if_pend) begin
          win_if = 1'b1;
        end else if (dm_pend) begin
          win_dm = 1'b1;
        end
      end
      e_flags = {win_if, win_dm, resp && !m_owner, resp && m_owner, win_if || win_dm,
                 win_dm && r_dm_we, if_pend && !(resp && !m_owner)};
      e_if_rdata = (resp && !m_owner) ? mem_rdata_i : 32'h0;
      e_dm_rdata = (resp && m_owner && !m_write) ? mem_rdata_i : 32'h0;
      e_addr  = win_if ? r_if_addr : (win_dm ? r_dm_addr : 32'h0);
      e_wdata = win_dm ? r_dm_wdata : 32'h0;
      chk($sformatf("rand_out_c%0d", c), outs(), mk(e_flags, e_if_rdata, e_dm_rdata, e_addr, e_wdata));
      chk($sformatf("rand_perf_c%0d", c), perf(), {64'b0, m_pi, m_pd, m_pc});

`ifdef ARB_PERF_CNT_EN
      if (win_if) m_pi = m_pi + 32'd1;
      if (win_dm) m_pd = m_pd + 32'd1;
      if (if_pend && dm_pend && arb && en_i) m_pc = m_pc + 32'd1;
`endif
      if (win_if) m_starve = 0;
      else if (if_pend && win_dm && m_starve < SL) m_starve = m_starve + 1;
      if (resp) m_busy = 1'b0;
      if (win_if || win_dm) begin
        m_busy  = 1'b1;
        m_due   = cyc + L;
        m_owner = win_dm;
        m_write = win_dm && r_dm_we;
      end
      if (win_if) begin if_pend = 1'b0; if_out = 1'b1; end
      if (win_dm) begin dm_pend = 1'b0; dm_out = 1'b1; end
      cyc++;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the fetch stage and the MEM stage of the 5-stage pipeline. Accepts one request at a time from each side and issues one access to memory. Returns each response after a fixed latency. Drives a fetch-stall indication that the hazard unit ORs into StallF/StallD. Priority: data over fetch, with a starvation guard that lets a waiting fetch win.

Parameters:
BITWIDTH, 32, address/data width
MEM_LATENCY, 2, cycles from memory issue to valid mem_rdata (legal range 1..7)
STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
en  in  1  global enable; 0 blocks new grants
if_req  in  1  fetch request
if_addr  in  BITWIDTH  fetch address (PCF)
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch response valid
if_rdata  out  BITWIDTH  fetched instruction (InstrF)
dm_req  in  1  data request
dm_we  in  1  1 = write (MemWriteM)
dm_addr  in  BITWIDTH  data address (ALUResultM)
dm_wdata  in  BITWIDTH  write data (WriteDataM)
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  data response valid (read data, or write acknowledge)
dm_rdata  out  BITWIDTH  read data (ReadDataM)
mem_req  out  1  memory access issue
mem_we  out  1  memory write enable
mem_addr  out  BITWIDTH  memory address
mem_wdata  out  BITWIDTH  memory write data
mem_rdata  in  BITWIDTH  memory read data, valid MEM_LATENCY cycles after mem_req
stall_f  out  1  if_req & ~if_rvalid (combinational)
perf_if_cnt, perf_dm_cnt, perf_conflict_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- State machine: IDLE and BUSY. BUSY carries a down-counter lat_cnt and an owner flag, owner = IF or DM.
- Arbitration happens when state == IDLE, or when state == BUSY and lat_cnt == 1 (the response cycle). The arbitration condition is called ARB. A grant requires en = 1.
- Winner selection: if only one side requests, that side wins. If both request, DM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- Grant cycle:
  - gnt, mem_req, mem_we, mem_addr and mem_wdata are driven combinationally in that cycle.
  - mem_we = dm_we for a DM grant, 0 for an IF grant.
  - mem_wdata = 0 for an IF grant.
  - Next cycle: state = BUSY, lat_cnt = MEM_LATENCY, owner = winner.
- Response: let T be the grant cycle. In cycle T+MEM_LATENCY:
  - The owner's rvalid = 1 for exactly one cycle.
  - The owner's rdata = mem_rdata.
  - For a DM write, dm_rvalid still pulses and dm_rdata = 0.
- Throughput is back-to-back: a new grant may occur in the response cycle. Peak rate is one access per MEM_LATENCY cycles.
- If MEM_LATENCY = 1, the response appears the cycle after the grant and the arbiter can grant every cycle.
- Requester protocol:
  - req, addr, we and wdata are held stable until gnt.
  - A requester has at most one outstanding access.
  - A requester does not assert req between its gnt and its rvalid, except in the rvalid cycle itself.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, in each cycle where if_req = 1 and dm_gnt = 1.
  - Clears on if_gnt.
  - Otherwise holds.
- en = 0:
  - No grants are issued.
  - An in-flight access still completes and its rvalid is still delivered.
  - starve_cnt holds.
- Outputs with no access present:
  - mem_addr, mem_wdata and mem_we = 0 when mem_req = 0.
  - rdata outputs = 0 when their rvalid = 0.
- Reset (asynchronous, rst = 0, at any time including mid-access):
  - state = IDLE, lat_cnt = 0, owner = IF, starve_cnt = 0.
  - All gnt, rvalid, rdata and mem_* outputs = 0; perf counters = 0.
  - The in-flight response is discarded; no rvalid is produced after reset releases.
- No combinational path from mem_rdata to any gnt.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, three 32-bit wrapping counters are built:
  - perf_if_cnt increments on each if_gnt.
  - perf_dm_cnt increments on each dm_gnt.
  - perf_conflict_cnt increments on each cycle with if_req & dm_req & ARB & en.
  - All three freeze while en = 0 and clear on reset.
- When undefined, the three perf ports remain present and are tied to 0; no counter flops are built.

Test Plan:
- MEM_LATENCY=2, single IF read at addr 0x10, mem returns 0x00500093 -> if_gnt in cycle 0; if_rvalid=1 with if_rdata=0x00500093 in cycle 2; stall_f=1 in cycles 0–1.
- Simultaneous if_req and dm_req (read 0x100) in IDLE -> dm_gnt in cycle 0; if_gnt in cycle 2 (the DM response cycle); if_rvalid in cycle 4.
- dm_req held high continuously with if_req, STARVE_LIMIT=4 -> DM wins 4 arbitrations; the 5th arbitration grants IF; starve_cnt then returns to 0.
- DM write to 0x200 with data 0xDEADBEEF -> mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF in the grant cycle; dm_rvalid=1 with dm_rdata=0 two cycles later.
- rst pulled low one cycle after an IF grant, released 2 cycles later -> no if_rvalid ever appears; all outputs 0; the next if_req is granted in the first cycle after release.
- en=0 while a DM access is in flight and if_req is pending -> dm_rvalid still arrives on time; no if_gnt until en=1; with ARB_PERF_CNT_EN defined, perf counters do not change while en=0.
